// File: rtl/bin_bcp_ctrl_pkg.sv
// Shared definitions for the clause-bin BCP controller slice.
//   VAR_W   : width of one variable-value field (three bits per literal)
//   state_t : controller state encoding, S_IDLE .. S_DONE
package bin_bcp_ctrl_pkg;

  localparam int VAR_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bin_bcp_ctrl_if.sv
// Bus between the BCP controller, the bin memory fetcher (var-value stream)
// and the lit array (row writes, implication drive, conflict/sat feedback).
//   master : controller side
//   slave  : fetcher / lit-array side
interface bin_bcp_ctrl_if
  import bin_bcp_ctrl_pkg::*;
#(
  parameter int NUM_LITS    = 4,
  parameter int NUM_CLAUSES = 8
);

  logic [NUM_LITS*VAR_W-1:0] vv_data_i;     // var values for current clause row
  logic                      vv_valid_i;
  logic                      vv_ready_o;
  logic                      wr_o;          // one row written per strobe
  logic [NUM_CLAUSES-1:0]    row_sel_o;     // one-hot, qualifies wr_o
  logic [NUM_LITS*VAR_W-1:0] var_value_o;
  logic                      imp_drv_o;
  logic                      cclause_drv_o;
  logic                      cclause_i;     // OR of row conflict outputs
  logic [NUM_CLAUSES-1:0]    clausesat_i;   // per-row satisfied flags

  modport master (
    input  vv_data_i, vv_valid_i, cclause_i, clausesat_i,
    output vv_ready_o, wr_o, row_sel_o, var_value_o, imp_drv_o, cclause_drv_o
  );

  modport slave (
    output vv_data_i, vv_valid_i, cclause_i, clausesat_i,
    input  vv_ready_o, wr_o, row_sel_o, var_value_o, imp_drv_o, cclause_drv_o
  );

endinterface

// File: rtl/bin_bcp_ctrl_popcount_n.sv
// Combinational population count.
//   bits  : N-bit input vector
//   count : number of set bits, W wide (W must hold N without wrapping)
module popcount_n #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/bin_bcp_ctrl.sv
// Sequences one clause bin: loads NUM_CLAUSES rows of var values into the lit
// array, drives implication for a settle window, samples conflict/sat and
// reports the result.
//   clk, rst   : clock, synchronous active-low reset
//   start_i    : begin a load+BCP pass (only honoured in IDLE)
//   bus        : fetcher stream + lit-array controls (master side)
//   busy_o     : pass in progress
//   done_o     : one-cycle end-of-pass pulse
//   conflict_o : pass hit a conflict (held until next start)
//   sat_cnt_o  : satisfied-clause count sampled in CHECK (held until next start)
module bin_bcp_ctrl
  import bin_bcp_ctrl_pkg::*;
#(
  parameter int  NUM_LITS    = 4,
  parameter int  NUM_CLAUSES = 8,
  parameter int  SETTLE_CYC  = 4,
  localparam int CW          = $clog2(NUM_CLAUSES + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  bin_bcp_ctrl_if.master bus,
  output logic           busy_o,
  output logic           done_o,
  output logic           conflict_o,
  output logic [CW-1:0]  sat_cnt_o
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int DW = NUM_LITS * VAR_W;
  localparam logic [NUM_CLAUSES-1:0] ROW_ONE = NUM_CLAUSES'(1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          row_q;          // rows accepted so far this pass
  logic [SW-1:0]          settle_q;       // SETTLE cycles elapsed
  logic                   conflict_flag_q;
  logic                   wr_q;
  logic [NUM_CLAUSES-1:0] row_sel_q;
  logic [DW-1:0]          var_value_q;
  logic                   conflict_q;
  logic [CW-1:0]          sat_cnt_q;
  logic [CW-1:0]          sat_pop;
  logic                   load_full;
  logic                   hs;

  popcount_n #(.N(NUM_CLAUSES), .W(CW)) u_popcount (
    .bits  (bus.clausesat_i),
    .count (sat_pop)
  );

  // Once every row is accepted, LOAD lingers one cycle with ready low so the
  // last row's write lands before implication starts.
  assign load_full      = (row_q == CW'(NUM_CLAUSES));
  assign bus.vv_ready_o = (state_q == S_LOAD) && !load_full;
  assign hs             = bus.vv_valid_i && bus.vv_ready_o;

  assign bus.wr_o          = wr_q;
  assign bus.row_sel_o     = row_sel_q;
  assign bus.var_value_o   = var_value_q;
  assign bus.imp_drv_o     = (state_q == S_SETTLE);
  assign bus.cclause_drv_o = (state_q == S_CHECK) && conflict_flag_q;

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign conflict_o = conflict_q;
  assign sat_cnt_o  = sat_cnt_q;

  // NOTE: every path must assign state_d; the default first keeps this purely
  // combinational instead of inferring a latch on unlisted paths.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD;
      S_LOAD:   if (load_full) state_d = S_SETTLE;
      S_SETTLE: if (bus.cclause_i || settle_q == SW'(SETTLE_CYC - 1)) state_d = S_CHECK;
      S_CHECK:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so rst is tested inside the clocked block and
  // kept out of the sensitivity list; all state uses non-blocking assignment
  // so every register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      settle_q        <= '0;
      conflict_flag_q <= 1'b0;
      wr_q            <= 1'b0;
      row_sel_q       <= '0;
      var_value_q     <= '0;
      conflict_q      <= 1'b0;
      sat_cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= hs;
      row_sel_q <= hs ? (ROW_ONE << row_q) : '0;
      if (hs) begin
        var_value_q <= bus.vv_data_i;
        row_q       <= row_q + CW'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            row_q           <= '0;
            settle_q        <= '0;
            conflict_flag_q <= 1'b0;
            conflict_q      <= 1'b0;
            sat_cnt_q       <= '0;
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q + SW'(1);
          if (bus.cclause_i) conflict_flag_q <= 1'b1;
        end
        S_CHECK: begin
          // Result registers become visible in DONE and hold until next start.
          sat_cnt_q  <= sat_pop;
          conflict_q <= conflict_flag_q;
        end
        default: ;
      endcase
    end
  end

endmodule
